// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared constants and the stereo sample pair type used by the
//               I2S frame generator and its sample FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int SAMPLE_W    = 32;    // bits per audio sample
    localparam int BITS_PER_CH = 32;    // SCLK periods per channel half-frame

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_t;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Synchronous FIFO of stereo sample pairs with an occupancy
//               output. No write-to-read bypass: the head only reflects
//               entries written on earlier edges.
// Ports       : clk        - system clock (rising edge)
//               reset_n    - asynchronous active-low reset, empties the FIFO
//               push       - write request (ignored while full)
//               push_data  - pair written at the tail
//               pop        - read request (ignored while empty)
//               head       - pair at the head
//               full/empty - occupancy flags
//               level      - number of occupied entries
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  stereo_t                  push_data,
    input  logic                     pop,
    output stereo_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    stereo_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_level == (PTR_W+1)'(DEPTH));
    assign empty     = (r_level == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];
    assign level     = r_level;

    // Depth is a power of two, so pointers wrap naturally at their width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/i2s_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2s_frame_gen
// Description : I2S frame timing generator. Buffers stereo pairs in a FIFO,
//               produces SCLK/LRCLK and presents each parallel sample to a
//               downstream serializer for a whole channel half-frame.
// Ports       : clk, reset_n          - clock, async active-low reset
//               s_valid/s_ready       - producer handshake
//               s_left/s_right        - stereo pair offered
//               sclk, lrclk           - bit clock and word select
//               i2s_data              - parallel sample for the serializer
//               fifo_level            - occupied FIFO entries
//               underrun/underrun_clr - sticky starvation flag and its clear
// Config      : I2S_UNDERRUN_REPEAT_EN - when defined, a starved frame
//               repeats the last popped pair instead of sending zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_frame_gen
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [SAMPLE_W-1:0]           s_left,
    input  logic [SAMPLE_W-1:0]           s_right,
    output logic                          sclk,
    output logic                          lrclk,
    output logic [SAMPLE_W-1:0]           i2s_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    input  logic                          underrun_clr
);

    logic [7:0]          r_div_cnt;
    logic                r_sclk;
    logic [4:0]          r_bit_cnt;
    logic                r_lrclk;
    logic [SAMPLE_W-1:0] r_data;
    logic [SAMPLE_W-1:0] r_hold;
    logic                r_underrun;

    logic                w_div_wrap;
    logic                w_sclk_fall;
    logic                w_lr_toggle;
    logic                w_lr_rise;
    logic                w_lr_fall;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    stereo_t             w_head;
    stereo_t             w_fill;    // pair presented when a frame starves

    assign w_div_wrap  = (r_div_cnt == 8'(SCLK_DIV-1));
    assign w_sclk_fall = w_div_wrap && r_sclk;
    // LRCLK flips together with the SCLK fall that wraps the bit counter.
    assign w_lr_toggle = w_sclk_fall && (r_bit_cnt == 5'(BITS_PER_CH-1));
    assign w_lr_rise   = w_lr_toggle && !r_lrclk;
    assign w_lr_fall   = w_lr_toggle && r_lrclk;

    assign s_ready     = !w_full;
    assign w_push      = s_valid && s_ready;
    assign w_pop       = w_lr_rise && !w_empty;

    sample_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data ({s_left, s_right}),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (fifo_level)
    );

`ifdef I2S_UNDERRUN_REPEAT_EN
    stereo_t r_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   r_last <= '0;
        else if (w_pop) r_last <= w_head;
    end

    assign w_fill = r_last;
`else
    assign w_fill = '0;
`endif

    // SCLK divider and bit counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
            r_bit_cnt <= '0;
            r_lrclk   <= 1'b0;
        end else begin
            r_div_cnt <= w_div_wrap ? 8'd0 : r_div_cnt + 8'd1;
            if (w_div_wrap)  r_sclk <= !r_sclk;
            if (w_sclk_fall) begin
                r_bit_cnt <= (r_bit_cnt == 5'(BITS_PER_CH-1)) ? 5'd0 : r_bit_cnt + 5'd1;
            end
            if (w_lr_toggle) r_lrclk <= !r_lrclk;
        end
    end

    // Sample presentation: left loaded at LRCLK rise, right (held) at fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data     <= '0;
            r_hold     <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (w_lr_rise) begin
                if (!w_empty) begin
                    r_data <= w_head.left;
                    r_hold <= w_head.right;
                end else begin
                    r_data <= w_fill.left;
                    r_hold <= w_fill.right;
                end
            end else if (w_lr_fall) begin
                r_data <= r_hold;
            end

            // Setting takes priority over a simultaneous clear.
            if (w_lr_rise && w_empty) r_underrun <= 1'b1;
            else if (underrun_clr)    r_underrun <= 1'b0;
        end
    end

    assign sclk     = r_sclk;
    assign lrclk    = r_lrclk;
    assign i2s_data = r_data;
    assign underrun = r_underrun;

endmodule
`default_nettype wire
